multicycle_core: RTL
====================

Name: multicycle_core

Overview:
Parametrised multicycle RV-subset core; the successor to our single-cycle processor. It keeps the same ISA subset, but sequences each instruction through an explicit FSM over one shared external memory bus with a req/ack handshake, instead of combinational instruction/data memories. XLEN is generic, and the core adds reset, halt, illegal-opcode detection and a retire strobe for the bench.

Parameters:
XLEN, 64, datapath, register and memory-bus data/address width (32 or 64)
RESET_PC, 0, PC value loaded on reset
NREGS, 32, architectural registers (x0 hardwired to zero); register index width is clog2(NREGS)

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears the core on the clk edge where it is sampled high
mem_req  output  1  bus request; held high until ack is sampled
mem_we  output  1  1 = store (sd), 0 = read (fetch or ld)
mem_addr  output  XLEN  byte address
mem_wdata  output  XLEN  store data
mem_rdata  input  XLEN  read data; valid in the cycle mem_ack=1
mem_ack  input  1  completion; may rise in the same cycle as mem_req (zero-wait slave)
pc  output  XLEN  address of the instruction in flight
retire  output  1  one-cycle pulse when an instruction completes
halted  output  1  core stopped (HALT state)
illegal  output  1  halt was caused by an unsupported encoding

Behaviour:
- Reset values: PC=RESET_PC, state=FETCH, all registers 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, halted=0, illegal=0. Reset mid-transaction abandons the bus cycle; req drops the next cycle.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: req=1, we=0, addr=PC. On ack, IR<=mem_rdata[31:0] (upper bits ignored), then go to DECODE. With no ack, stay in FETCH with outputs stable.
- DECODE:
  - A<=rf[rs1], B<=rf[rs2], imm sign-extended to XLEN (I, S or B format).
  - Opcode 0000000 -> HALT with illegal=0.
  - Any unsupported opcode, funct3 or funct7 -> HALT with illegal=1.
  - Otherwise -> EXEC.
- Supported instructions: add, sub, and, or (0110011; funct7 0000000 or 0100000 for sub only); addi (0010011, f3=000); ld (0000011, f3=011); sd (0100011, f3=011); beq and bne (1100011, f3 000 and 001).
- EXEC:
  - ALUout<=A op (B or imm). Arithmetic wraps modulo 2^XLEN; no overflow trap.
  - beq/bne: compare A and B. If taken, PC<=PC+imm, else PC<=PC+4; retire=1; -> FETCH.
  - ld/sd -> MEM. R-type and addi -> WB.
- MEM: req=1, addr=ALUout, we=1 for sd with wdata=B, we=0 for ld. On ack:
  - sd: PC+=4, retire=1, -> FETCH.
  - ld: MDR<=rdata, -> WB.
- WB: rd<=ALUout, or MDR for ld. Writes to x0 are discarded. PC+=4, retire=1, -> FETCH.
- Latency with zero-wait memory: branch 3 cycles, R/addi 4, sd 4, ld 5. Each cycle of ack delay adds one cycle.
- retire is registered and high for exactly the single cycle after the completing edge.
- HALT:
  - req=0, halted=1, PC frozen at the offending instruction.
  - Only reset exits HALT.
- Misaligned addresses are passed to the bus unchanged; alignment is the slave's responsibility.

Optional Feature:
CORE_PERF_CNT_EN
- Defined: adds output ports cycle_cnt (XLEN) and instret_cnt (XLEN).
  - Both clear on reset and wrap modulo 2^XLEN.
  - cycle_cnt increments every non-HALT cycle.
  - instret_cnt increments on every retire.
- Undefined: the ports and the counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then zero-wait memory with program "addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; 0" -> x3=2, x4=-8 (all ones except 0x..F8). retire pulses at cycles 4, 8, 12 and 16; then halted=1, illegal=0, pc=16.
2. Store/load: "addi x1,x0,0x80; addi x5,x0,77; sd x5,8(x1); ld x6,8(x1)" -> a write bus cycle with addr=0x88, wdata=77, then x6=77. The ld takes 5 cycles.
3. Branch loop: x1=3 decremented by addi x1,x1,-1 with "bne x1,x0,-4" -> the bne is taken twice, then falls through; final x1=0 and PC advances past the loop.
4. Wait states: ack delayed 3 cycles on every access -> req/addr/we stay stable until ack, each access stretches by exactly 3 cycles, and results match scenario 1.
5. Illegal encoding 0x0000707F at PC=0x10 -> halted=1, illegal=1, pc=0x10, no register written. Asserting reset for one cycle then restarts fetch at RESET_PC.
6. XLEN=32 build: addi x1,x0,-1; add x2,x1,x1 -> x2=0xFFFFFFFE. Writing to x0 ("addi x0,x0,9") leaves x0=0. With CORE_PERF_CNT_EN defined, instret_cnt=3 after halt.

Source files
------------

// File: rtl/multicycle_core.sv
// Multicycle RV-subset core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB
// over a single req/ack memory bus. Optional perf counters under CORE_PERF_CNT_EN.
module multicycle_core #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted,
    output logic            illegal
`ifdef CORE_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
`endif
);

    localparam int RW = $clog2(NREGS);

    localparam logic [6:0] OPC_HALT  = 7'b0000000;
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR
    } alu_op_t;

    typedef struct packed {
        logic            legal;
        logic            stop;
        logic            is_ld;
        logic            is_sd;
        logic            is_br;
        logic            use_imm;
        alu_op_t         op;
        logic [XLEN-1:0] imm;
    } dec_t;

    state_t          state, nstate;
    logic [31:0]     ir, ir_d;
    logic [XLEN-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
    logic [XLEN-1:0] a_d, b_d, imm_d, alu_d, mdr_d;
    logic [XLEN-1:0] rf [NREGS];

    logic            req_d, we_d, retire_d, ill_d;
    logic [XLEN-1:0] addr_d, wdata_d, pc_d;
    logic            rf_we;
    logic [RW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    dec_t            dec;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] opb, alu_res, pc_inc;
    logic            taken;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[7 +: RW];
    assign rs1    = ir[15 +: RW];
    assign rs2    = ir[20 +: RW];

    // Decode is purely a function of IR, which stays stable from DECODE through WB.
    always_comb begin
        dec         = '0;
        dec.op      = ALU_ADD;
        dec.imm     = {{(XLEN-12){ir[31]}}, ir[31:20]};
        case (opcode)
            OPC_HALT: dec.stop = 1'b1;
            OPC_R: begin
                dec.legal = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.op = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.op = ALU_SUB;
                    {7'b0000000, 3'b111}: dec.op = ALU_AND;
                    {7'b0000000, 3'b110}: dec.op = ALU_OR;
                    default:              dec.legal = 1'b0;
                endcase
            end
            OPC_IMM: begin
                dec.legal   = (funct3 == 3'b000);
                dec.use_imm = 1'b1;
            end
            OPC_LOAD: begin
                dec.legal   = (funct3 == 3'b011);
                dec.is_ld   = 1'b1;
                dec.use_imm = 1'b1;
            end
            OPC_STORE: begin
                dec.legal   = (funct3 == 3'b011);
                dec.is_sd   = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            end
            OPC_BR: begin
                dec.legal = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec.is_br = 1'b1;
                dec.imm   = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            default: dec.legal = 1'b0;
        endcase
    end

    assign opb    = dec.use_imm ? imm_q : b_q;
    assign taken  = funct3[0] ? (a_q != b_q) : (a_q == b_q);
    assign pc_inc = pc + XLEN'(4);

    always_comb begin
        case (dec.op)
            ALU_SUB: alu_res = a_q - opb;
            ALU_AND: alu_res = a_q & opb;
            ALU_OR:  alu_res = a_q | opb;
            default: alu_res = a_q + opb;
        endcase
    end

    // Bus outputs are registered, so each transition that starts a bus cycle
    // loads req/addr/we here; the first FETCH after reset spends one cycle raising req.
    always_comb begin
        nstate   = state;
        req_d    = mem_req;
        we_d     = mem_we;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        pc_d     = pc;
        ir_d     = ir;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        ill_d    = illegal;
        retire_d = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = rd;
        rf_wd    = alu_q;
        case (state)
            S_FETCH: begin
                if (!mem_req) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc;
                end else if (mem_ack) begin
                    ir_d   = mem_rdata[31:0];
                    req_d  = 1'b0;
                    nstate = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rf[rs1];
                b_d   = rf[rs2];
                imm_d = dec.imm;
                if (dec.stop) begin
                    nstate = S_HALT;
                end else if (!dec.legal) begin
                    nstate = S_HALT;
                    ill_d  = 1'b1;
                end else begin
                    nstate = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (dec.is_br) begin
                    pc_d     = taken ? pc + imm_q : pc_inc;
                    retire_d = 1'b1;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = pc_d;
                    nstate   = S_FETCH;
                end else if (dec.is_ld || dec.is_sd) begin
                    req_d   = 1'b1;
                    we_d    = dec.is_sd;
                    addr_d  = alu_res;
                    wdata_d = b_q;
                    nstate  = S_MEM;
                end else begin
                    nstate = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (dec.is_sd) begin
                        pc_d     = pc_inc;
                        retire_d = 1'b1;
                        req_d    = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = pc_inc;
                        nstate   = S_FETCH;
                    end else begin
                        mdr_d  = mem_rdata;
                        req_d  = 1'b0;
                        we_d   = 1'b0;
                        nstate = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = (rd != '0);
                rf_wd    = dec.is_ld ? mdr_q : alu_q;
                pc_d     = pc_inc;
                retire_d = 1'b1;
                req_d    = 1'b1;
                we_d     = 1'b0;
                addr_d   = pc_inc;
                nstate   = S_FETCH;
            end
            S_HALT: begin
                req_d = 1'b0;
                we_d  = 1'b0;
            end
            default: nstate = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            retire    <= 1'b0;
            illegal   <= 1'b0;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            state     <= nstate;
            pc        <= pc_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            retire    <= retire_d;
            illegal   <= ill_d;
            ir        <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            if (rf_we) rf[rf_wa] <= rf_wd;
        end
    end

    assign halted = (state == S_HALT);

`ifdef CORE_PERF_CNT_EN
    // instret counts on the same edge that raises retire, so both are visible together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_HALT) cycle_cnt <= cycle_cnt + XLEN'(1);
            if (retire_d) instret_cnt <= instret_cnt + XLEN'(1);
        end
    end
`endif

endmodule
